sp_link_ctrl: RTL and testbench

Receive-side framing controller for the serial link, clocked by clk_8f.
- Shifts in one serial bit per cycle and hunts for the COM symbol, 0xBC.
- Declares byte alignment (lock) after LOCK_COUNT consecutive aligned COMs.
- While locked, delivers parallel bytes with a valid flag and a one-cycle byte strobe.
- Sits between the serial line and the parallel consumer; it replaces the externally supplied clk_f byte timing with an internally derived strobe.

---
 rtl/sp_link_ctrl_pkg.sv | 18 +
 rtl/sp_link_ctrl_if.sv | 22 ++
 rtl/sp_shift_window.sv | 27 ++
 rtl/sp_link_ctrl.sv | 119 +++++++++++
 tb/tb_sp_link_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sp_link_ctrl_pkg.sv
// Shared constants and FSM state type for the serial link framing controller.
package sp_link_ctrl_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned COM_CNT_W = 4;

    localparam logic [BYTE_W-1:0] COM_SYM_DEF    = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE_SYM_DEF   = 8'h7C;
    localparam int unsigned       LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } link_state_e;

endpackage

// File: rtl/sp_link_ctrl_if.sv
// Serial-in / parallel-out link bundle between the line side and the byte consumer.
interface sp_link_ctrl_if;
    import sp_link_ctrl_pkg::*;

    logic              serial_in;
    logic              relock;
    logic [BYTE_W-1:0] byte_out;
    logic              valid_out;
    logic              byte_strobe;
    logic              active;

    modport master (
        output serial_in, relock,
        input  byte_out, valid_out, byte_strobe, active
    );

    modport slave (
        input  serial_in, relock,
        output byte_out, valid_out, byte_strobe, active
    );

endinterface

// File: rtl/sp_shift_window.sv
// 8-bit serial shift register with the live window (history plus current bit) and COM detect.
module sp_shift_window
    import sp_link_ctrl_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYM = COM_SYM_DEF
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic              serial_i,
    output logic [BYTE_W-1:0] window_c,
    output logic              is_com_c
);

    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_d;

    assign shift_d  = {shift_q[BYTE_W-2:0], serial_i};
    assign window_c = shift_d;
    assign is_com_c = (shift_d == COM_SYM);

    // Shifts on every edge, relock included; only reset clears history.
    always_ff @(posedge clk_8f) begin
        if (reset) shift_q <= '0;
        else       shift_q <= shift_d;
    end

endmodule

// File: rtl/sp_link_ctrl.sv
// Receive framing controller: hunts for COM, aligns after LOCK_COUNT boundary COMs, then emits bytes.
module sp_link_ctrl
    import sp_link_ctrl_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYM    = COM_SYM_DEF,
    parameter logic [BYTE_W-1:0] IDLE_SYM   = IDLE_SYM_DEF,
    parameter int unsigned       LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic          clk_8f,
    input  logic          reset,
    sp_link_ctrl_if.slave link
);

    link_state_e          state_q,  state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [COM_CNT_W-1:0] com_cnt_q, com_cnt_d;
    logic [BYTE_W-1:0]    byte_q,   byte_d;
    logic                 valid_q,  valid_d;
    logic                 strobe_q, strobe_d;
    logic                 active_q, active_d;

    logic [BYTE_W-1:0]    window_c;
    logic                 is_com_c;
    logic                 boundary_c;
    logic                 lock_hit_c;

    sp_shift_window #(.COM_SYM(COM_SYM)) u_win (
        .clk_8f   (clk_8f),
        .reset    (reset),
        .serial_i (link.serial_in),
        .window_c (window_c),
        .is_com_c (is_com_c)
    );

    assign boundary_c = (bit_cnt_q == BIT_CNT_W'(7));
    assign lock_hit_c = ((32'(com_cnt_q) + 32'd1) == LOCK_COUNT);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;

        if (link.relock) begin
            state_d   = ST_HUNT;
            bit_cnt_d = '0;
            com_cnt_d = '0;
            byte_d    = IDLE_SYM;
            valid_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    bit_cnt_d = '0;
                    if (is_com_c) begin
                        com_cnt_d = COM_CNT_W'(1);
                        state_d   = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (boundary_c) begin
                        if (!is_com_c) begin
                            state_d   = ST_HUNT;
                            com_cnt_d = '0;
                            bit_cnt_d = '0;
                        end else if (lock_hit_c) begin
                            state_d   = ST_LOCKED;
                        end else begin
                            com_cnt_d = com_cnt_q + COM_CNT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (boundary_c) begin
                        strobe_d = 1'b1;
                        byte_d   = is_com_c ? IDLE_SYM : window_c;
                        valid_d  = !is_com_c;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = '0;
                    com_cnt_d = '0;
                end
            endcase
        end

        active_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            byte_q    <= IDLE_SYM;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign link.byte_out    = byte_q;
    assign link.valid_out   = valid_q;
    assign link.byte_strobe = strobe_q;
    assign link.active      = active_q;

endmodule

// File: tb/tb_sp_link_ctrl.sv
// Directed bench for sp_link_ctrl with a bit-history reference model and strobe capture.
module tb_sp_link_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 1'b0;

    sp_link_ctrl_if lnk();

    sp_link_ctrl dut (
        .clk_8f (clk),
        .reset  (reset),
        .link   (lnk)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=searching, 1=aligning, 2=locked; bits counted since last anchor.
    logic [7:0] m_hist   = 8'h00;
    int         m_mode   = 0;
    int         m_since  = 0;
    int         m_coms   = 0;
    logic [7:0] m_byte   = 8'h7C;
    logic       m_valid  = 1'b0;
    logic       m_strobe = 1'b0;

    always @(posedge clk) begin : model
        logic [7:0] w;
        w = {m_hist[6:0], lnk.serial_in};
        m_hist = w;
        if (reset) begin
            m_hist = 8'h00; m_mode = 0; m_since = 0; m_coms = 0;
            m_byte = 8'h7C; m_valid = 1'b0; m_strobe = 1'b0;
        end else if (lnk.relock) begin
            m_mode = 0; m_since = 0; m_coms = 0;
            m_byte = 8'h7C; m_valid = 1'b0; m_strobe = 1'b0;
        end else begin
            m_strobe = 1'b0;
            m_since  = m_since + 1;
            if (m_mode == 0) begin
                if (w == 8'hBC) begin m_mode = 1; m_coms = 1; m_since = 0; end
            end else if (m_since == 8) begin
                m_since = 0;
                if (m_mode == 1) begin
                    if (w == 8'hBC) begin
                        m_coms = m_coms + 1;
                        if (m_coms == 4) m_mode = 2;
                    end else begin
                        m_mode = 0; m_coms = 0;
                    end
                end else begin
                    m_strobe = 1'b1;
                    m_byte   = (w == 8'hBC) ? 8'h7C : w;
                    m_valid  = (w != 8'hBC);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_byte",   32'(lnk.byte_out),    32'(m_byte));
            chk("model_valid",  32'(lnk.valid_out),   32'(m_valid));
            chk("model_strobe", 32'(lnk.byte_strobe), 32'(m_strobe));
            chk("model_active", 32'(lnk.active),      32'(m_mode == 2));
        end
    end

    logic [8:0] cap_q [$];
    logic [8:0] exp_q [$];

    always @(negedge clk) begin
        if (cmp_en && lnk.byte_strobe) cap_q.push_back({lnk.valid_out, lnk.byte_out});
    end

    task automatic check_q(input string nm);
        chk({nm, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size()) chk({nm, "_entry"}, 32'(cap_q[i]), 32'(exp_q[i]));
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        lnk.serial_in = b;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_coms(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hBC);
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_byte"},   32'(lnk.byte_out),    32'h7C);
        chk({nm, "_valid"},  32'(lnk.valid_out),   32'h0);
        chk({nm, "_strobe"}, 32'(lnk.byte_strobe), 32'h0);
        chk({nm, "_active"}, 32'(lnk.active),      32'h0);
    endtask

    task automatic pulse_relock();
        @(negedge clk);
        lnk.relock    = 1'b1;
        lnk.serial_in = 1'b0;
        settle();
        chk_idle("relock");
        @(negedge clk);
        lnk.relock = 1'b0;
    endtask

    task automatic lock_check(input string nm);
        send_coms(4);
        settle();
        chk({nm, "_active"}, 32'(lnk.active), 32'h1);
        chk({nm, "_nostrobe"}, 32'(lnk.byte_strobe), 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        lnk.relock    = 1'b0;
        lnk.serial_in = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;

        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        settle();
        chk_idle("reset");
        @(negedge clk);
        reset         = 1'b0;
        lnk.serial_in = 1'b0;
        settle();
        chk_idle("post_reset");
        pad(2);

        lock_check("lock");
        send_byte(8'hFF); send_byte(8'hEE); send_byte(8'h4E); send_byte(8'h44);
        send_byte(8'h11); send_byte(8'hBC); send_byte(8'h22);
        pad(4);
        exp_q.push_back(9'h1FF); exp_q.push_back(9'h1EE); exp_q.push_back(9'h14E);
        exp_q.push_back(9'h144); exp_q.push_back(9'h111); exp_q.push_back(9'h07C);
        exp_q.push_back(9'h122);
        check_q("lockdata");
        chk("com_active", 32'(lnk.active), 32'h1);

        pulse_relock();
        lock_check("relock_lock");
        send_byte(8'h5A);
        pad(4);
        exp_q.push_back(9'h15A);
        check_q("relock_data");

        pulse_relock();
        send_coms(3);
        send_byte(8'h11); send_byte(8'h11);
        settle();
        chk("alignfail_active", 32'(lnk.active), 32'h0);
        lock_check("alignfail_lock");
        send_byte(8'h33);
        pad(4);
        exp_q.push_back(9'h133);
        check_q("alignfail_data");

        pulse_relock();
        send_byte(8'h0B); send_byte(8'hC0); send_byte(8'h00);
        settle();
        chk("straddle_active", 32'(lnk.active), 32'h0);
        lock_check("straddle_lock");
        send_byte(8'h69);
        pad(4);
        exp_q.push_back(9'h169);
        check_q("straddle_data");

        pad(3);
        @(negedge clk);
        reset = 1'b1;
        settle();
        chk_idle("midreset");
        @(negedge clk);
        reset = 1'b0;
        lock_check("midreset_lock");
        send_byte(8'h77);
        pad(4);
        exp_q.push_back(9'h177);
        check_q("midreset_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
